// File: rtl/game_result_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : game_result_sequencer                                        |
// | Description : Timed mode-number / O-X result sequencer feeding the 8x8     |
// |               dot-matrix driver. Optional macro: RESULT_BLINK_EN.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module game_result_sequencer #(
  parameter int MODE_SHOW_CYCLES   = 100_000_000,
  parameter int RESULT_HOLD_CYCLES = 150_000_000,
  parameter int BLINK_HALF_CYCLES  = 12_500_000,
  parameter int CNT_W              = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       all_off,
  input  logic       answer_valid,
  input  logic       answer_correct,
  output logic [1:0] show_mode_num,
  output logic       game_win,
  output logic       game_lose,
  output logic       busy
);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    SHOW_MODE = 2'd1,
    IDLE      = 2'd2,
    RESULT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_mode_last   = CNT_W'(MODE_SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_result_last = CNT_W'(RESULT_HOLD_CYCLES - 1);

  generate
    if (MODE_SHOW_CYCLES < 1 || RESULT_HOLD_CYCLES < 1 || BLINK_HALF_CYCLES < 1) begin : g_param_check
      $error("game_result_sequencer: cycle parameters must be >= 1");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic             r_mode_q, w_mode_q_nxt;
  logic [1:0]       w_show_nxt;
  logic             w_win_nxt, w_lose_nxt, w_busy_nxt;

`ifdef RESULT_BLINK_EN
  localparam logic [CNT_W-1:0] c_blink_last = CNT_W'(BLINK_HALF_CYCLES - 1);
  logic [CNT_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic             r_blink_on, w_blink_on_nxt;
  logic             r_correct, w_correct_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_mode_q_nxt = r_mode_q;
    w_show_nxt   = show_mode_num;
    w_win_nxt    = game_win;
    w_lose_nxt   = game_lose;
`ifdef RESULT_BLINK_EN
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_on_nxt  = r_blink_on;
    w_correct_nxt   = r_correct;
`endif

    case (r_state)
      BOOT: begin
        w_state_nxt  = SHOW_MODE;
        w_mode_q_nxt = mode;
        w_show_nxt   = {mode, ~mode};
        w_timer_nxt  = '0;
        w_win_nxt    = 1'b0;
        w_lose_nxt   = 1'b0;
      end
      SHOW_MODE: begin
        if (r_timer == c_mode_last) begin
          w_state_nxt = IDLE;
          w_show_nxt  = 2'd0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      IDLE: begin
        if (mode && answer_valid && !all_off) begin
          w_state_nxt = RESULT;
          w_timer_nxt = '0;
          w_win_nxt   = answer_correct;
          w_lose_nxt  = ~answer_correct;
`ifdef RESULT_BLINK_EN
          w_blink_cnt_nxt = '0;
          w_blink_on_nxt  = 1'b1;
          w_correct_nxt   = answer_correct;
`endif
        end
      end
      RESULT: begin
        // all_off beats a simultaneous new answer
        if (all_off || (!answer_valid && r_timer == c_result_last)) begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
          w_win_nxt   = 1'b0;
          w_lose_nxt  = 1'b0;
        end else if (answer_valid) begin
          w_timer_nxt = '0;
          w_win_nxt   = answer_correct;
          w_lose_nxt  = ~answer_correct;
`ifdef RESULT_BLINK_EN
          w_blink_cnt_nxt = '0;
          w_blink_on_nxt  = 1'b1;
          w_correct_nxt   = answer_correct;
`endif
        end else begin
          w_timer_nxt = r_timer + 1'b1;
`ifdef RESULT_BLINK_EN
          if (r_blink_cnt == c_blink_last) begin
            w_blink_cnt_nxt = '0;
            w_blink_on_nxt  = ~r_blink_on;
          end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
          end
          w_win_nxt  = r_correct & w_blink_on_nxt;
          w_lose_nxt = ~r_correct & w_blink_on_nxt;
`endif
        end
      end
      default: w_state_nxt = BOOT;
    endcase

    // A mode switch overrides everything decided above
    if (r_state != BOOT && mode != r_mode_q) begin
      w_state_nxt  = SHOW_MODE;
      w_mode_q_nxt = mode;
      w_show_nxt   = {mode, ~mode};
      w_timer_nxt  = '0;
      w_win_nxt    = 1'b0;
      w_lose_nxt   = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_timer       <= '0;
      r_mode_q      <= 1'b0;
      show_mode_num <= 2'd0;
      game_win      <= 1'b0;
      game_lose     <= 1'b0;
      busy          <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_mode_q      <= w_mode_q_nxt;
      show_mode_num <= w_show_nxt;
      game_win      <= w_win_nxt;
      game_lose     <= w_lose_nxt;
      busy          <= w_busy_nxt;
    end
  end

`ifdef RESULT_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
      r_correct   <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_on  <= w_blink_on_nxt;
      r_correct   <= w_correct_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_result_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_game_result_sequencer                                     |
// | Description : Directed self-checking bench for game_result_sequencer.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_game_result_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       all_off;
  logic       answer_valid;
  logic       answer_correct;
  logic [1:0] show_mode_num;
  logic       game_win;
  logic       game_lose;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  game_result_sequencer #(
    .MODE_SHOW_CYCLES  (10),
    .RESULT_HOLD_CYCLES(20),
    .BLINK_HALF_CYCLES (4),
    .CNT_W             (28)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode          (mode),
    .all_off       (all_off),
    .answer_valid  (answer_valid),
    .answer_correct(answer_correct),
    .show_mode_num (show_mode_num),
    .game_win      (game_win),
    .game_lose     (game_lose),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected active-flag level on the i-th cycle (1-based) of a result hold
  function automatic logic exp_flag(input int i);
`ifdef RESULT_BLINK_EN
    return (((i - 1) / 4) % 2) == 0;
`else
    return (i >= 1);
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; all_off = 1'b0; answer_valid = 1'b0; answer_correct = 1'b0;
    repeat (3) tick();
    checks++;
    if (show_mode_num !== 2'd0 || game_win !== 1'b0 || game_lose !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset: show=%0d win=%b lose=%b busy=%b, want 0 0 0 1", show_mode_num, game_win, game_lose, busy);
    end
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (show_mode_num !== 2'd2 || game_win !== 1'b0 || game_lose !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL boot_show[%0d]: show=%0d win=%b lose=%b busy=%b, want 2 0 0 1", i, show_mode_num, game_win, game_lose, busy);
      end
    end
    tick();
    checks++;
    if (show_mode_num !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL boot_end: show=%0d busy=%b, want 0 0", show_mode_num, busy);
    end
  endtask

  task automatic test_mode_toggle();
    mode = 1'b0;
    tick();
    checks++;
    if (show_mode_num !== 2'd1) begin
      fails++;
      $display("FAIL toggle_enter: show=%0d, want 1", show_mode_num);
    end
    repeat (4) tick();
    checks++;
    if (show_mode_num !== 2'd1) begin
      fails++;
      $display("FAIL toggle_mid: show=%0d, want 1", show_mode_num);
    end
    mode = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (show_mode_num !== 2'd2) begin
        fails++;
        $display("FAIL toggle_restart[%0d]: show=%0d, want 2", i, show_mode_num);
      end
    end
    tick();
    checks++;
    if (show_mode_num !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL toggle_end: show=%0d busy=%b, want 0 0", show_mode_num, busy);
    end
  endtask

  task automatic test_win();
    answer_valid = 1'b1; answer_correct = 1'b1;
    tick();
    answer_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) tick();
      checks++;
      if (game_win !== exp_flag(i) || game_lose !== 1'b0 || show_mode_num !== 2'd0) begin
        fails++;
        $display("FAIL win_hold[%0d]: win=%b lose=%b show=%0d, want %b 0 0", i, game_win, game_lose, show_mode_num, exp_flag(i));
      end
    end
    tick();
    checks++;
    if (game_win !== 1'b0 || game_lose !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL win_end: win=%b lose=%b busy=%b, want 0 0 0", game_win, game_lose, busy);
    end
  endtask

  task automatic test_early_clear();
    answer_valid = 1'b1; answer_correct = 1'b0;
    tick();
    answer_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (game_lose !== exp_flag(7) || game_win !== 1'b0) begin
      fails++;
      $display("FAIL clear_before: lose=%b win=%b, want %b 0", game_lose, game_win, exp_flag(7));
    end
    all_off = 1'b1;
    tick();
    checks++;
    if (game_lose !== 1'b0 || game_win !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_after: lose=%b win=%b busy=%b, want 0 0 0", game_lose, game_win, busy);
    end
    // answer together with all_off is ignored
    answer_valid = 1'b1; answer_correct = 1'b1;
    tick();
    answer_valid = 1'b0;
    checks++;
    if (game_win !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL answer_all_off: win=%b busy=%b, want 0 0", game_win, busy);
    end
    all_off = 1'b0;
  endtask

  task automatic test_replace();
    answer_valid = 1'b1; answer_correct = 1'b1;
    tick();
    answer_valid = 1'b0;
    repeat (11) tick();
    checks++;
    if (game_win !== exp_flag(12)) begin
      fails++;
      $display("FAIL replace_before: win=%b, want %b", game_win, exp_flag(12));
    end
    answer_valid = 1'b1; answer_correct = 1'b0;
    tick();
    answer_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) tick();
      checks++;
      if (game_lose !== exp_flag(i) || game_win !== 1'b0) begin
        fails++;
        $display("FAIL replace_hold[%0d]: lose=%b win=%b, want %b 0", i, game_lose, game_win, exp_flag(i));
      end
    end
    tick();
    checks++;
    if (game_lose !== 1'b0 || game_win !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL replace_end: lose=%b win=%b busy=%b, want 0 0 0", game_lose, game_win, busy);
    end
  endtask

  task automatic test_ignored();
    mode = 1'b0;
    tick();
    answer_valid = 1'b1; answer_correct = 1'b1;
    tick();
    answer_valid = 1'b0;
    checks++;
    if (game_win !== 1'b0 || game_lose !== 1'b0 || show_mode_num !== 2'd1) begin
      fails++;
      $display("FAIL ignore_show: win=%b lose=%b show=%0d, want 0 0 1", game_win, game_lose, show_mode_num);
    end
    repeat (8) tick();
    checks++;
    if (show_mode_num !== 2'd1) begin
      fails++;
      $display("FAIL ignore_show_last: show=%0d, want 1", show_mode_num);
    end
    tick();
    checks++;
    if (show_mode_num !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_show_end: show=%0d busy=%b, want 0 0", show_mode_num, busy);
    end
    answer_valid = 1'b1; answer_correct = 1'b0;
    tick();
    answer_valid = 1'b0;
    checks++;
    if (game_win !== 1'b0 || game_lose !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_basic: win=%b lose=%b busy=%b, want 0 0 0", game_win, game_lose, busy);
    end
    mode = 1'b1;
    repeat (11) tick();
    checks++;
    if (show_mode_num !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_back_idle: show=%0d busy=%b, want 0 0", show_mode_num, busy);
    end
  endtask

  task automatic test_async_reset();
    answer_valid = 1'b1; answer_correct = 1'b1;
    tick();
    answer_valid = 1'b0;
    repeat (2) tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (game_win !== 1'b0 || game_lose !== 1'b0 || show_mode_num !== 2'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: win=%b lose=%b show=%0d busy=%b, want 0 0 0 1", game_win, game_lose, show_mode_num, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (show_mode_num !== 2'd2 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reboot: show=%0d busy=%b, want 2 1", show_mode_num, busy);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_mode_toggle();
    test_win();
    test_early_clear();
    test_replace();
    test_ignored();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
